// File: rtl/down_count_timer.sv
// down_count_timer
// Loadable 8-bit countdown timer with a prescaled step rate.
// The count runs to zero and holds there, raising a Done level and a one-cycle
// Tc pulse. The live count is shown on two active-low 7-segment digits.
module down_count_timer #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Enable,
    output logic [WIDTH-1:0] Q,
    output logic             Done,
    output logic             Tc,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1
);

    // The prescaler needs at least one bit even when every cycle is a tick.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] q_reg;
    logic [PW-1:0]    pre_reg;
    logic             done_reg;
    logic             tc_reg;

    // True when the next tick is the final step down to zero. A zero count is
    // folded in so the counter can never wrap below zero.
    logic             last_step;
    assign last_step = (q_reg == WIDTH'(1)) || (q_reg == '0);

    // Timer state machine: reset, then load, then the enabled count step.
    // Enable acts directly on the edge it is sampled, so a paused timer that
    // sees Enable high advances its held prescaler on that same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            pre_reg   <= '0;
            done_reg  <= 1'b0;
            tc_reg    <= 1'b0;
        end else begin
            tc_reg <= 1'b0;
            if (Load) begin
                q_reg   <= LoadValue;
                pre_reg <= '0;
                if (LoadValue == '0) begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end else begin
                    state_reg <= Enable ? RUN : PAUSE;
                    done_reg  <= 1'b0;
                end
            end else begin
                case (state_reg)
                    RUN, PAUSE: begin
                        if (Enable) begin
                            state_reg <= RUN;
                            if (pre_reg == PRE_LAST) begin
                                pre_reg <= '0;
                                if (last_step) begin
                                    q_reg     <= '0;
                                    tc_reg    <= 1'b1;
                                    done_reg  <= 1'b1;
                                    state_reg <= DONE;
                                end else begin
                                    q_reg <= q_reg - 1'b1;
                                end
                            end else begin
                                pre_reg <= pre_reg + 1'b1;
                            end
                        end else begin
                            // Freeze count and prescaler; no step on this edge.
                            state_reg <= PAUSE;
                        end
                    end
                    default: begin
                        // IDLE and DONE hold until a load or reset.
                        state_reg <= state_reg;
                    end
                endcase
            end
        end
    end

    assign Q    = q_reg;
    assign Done = done_reg;
    assign Tc   = tc_reg;

    // Active-low segment pattern for one hex nibble, bit 0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // The display always covers an 8-bit view of the count.
    logic [7:0]      q_hex;
    logic [1:0][6:0] hex_digits;
    assign q_hex = 8'(q_reg);

    // One decoder per displayed nibble, driven straight from the count register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_hex
        assign hex_digits[gi] = seg7(q_hex[gi*4 +: 4]);
    end

    assign HEX0 = hex_digits[0];
    assign HEX1 = hex_digits[1];

endmodule

// File: tb/tb_down_count_timer.sv
// tb_down_count_timer
// Directed scenarios followed by random stimulus, every cycle compared against
// a behavioural model that counts enabled cycles since the last load.
module tb_down_count_timer;

    localparam int TICK_DIV = 4;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld  = 1'b0;
    logic [7:0] lv  = 8'h00;
    logic       en  = 1'b0;
    logic [7:0] q;
    logic       done;
    logic       tc;
    logic [6:0] hex0;
    logic [6:0] hex1;

    int errors = 0;
    int checks = 0;

    // Reference model: count value, enabled cycles since load, active/done flags.
    logic [7:0] m_q      = 8'h00;
    int         m_steps  = 0;
    bit         m_active = 0;
    bit         m_done   = 0;
    bit         m_tc     = 0;

    always #5 clk = ~clk;

    down_count_timer #(.WIDTH(8), .TICK_DIV(TICK_DIV)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .Load      (ld),
        .LoadValue (lv),
        .Enable    (en),
        .Q         (q),
        .Done      (done),
        .Tc        (tc),
        .HEX0      (hex0),
        .HEX1      (hex1)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input logic r, input logic l, input logic [7:0] v, input logic e);
        rst = r; ld = l; lv = v; en = e;
        @(posedge clk);
        m_tc = 0;
        if (r) begin
            m_q = 8'h00; m_steps = 0; m_active = 0; m_done = 0;
        end else if (l) begin
            m_q = v; m_steps = 0; m_active = (v != 0); m_done = (v == 0);
        end else if (m_active && e) begin
            m_steps++;
            if (m_steps % TICK_DIV == 0) begin
                m_q = m_q - 8'd1;
                if (m_q == 0) begin
                    m_tc = 1; m_active = 0; m_done = 1;
                end
            end
        end
        #1;
        chk("q",    32'(q),    32'(m_q));
        chk("done", 32'(done), 32'(m_done));
        chk("tc",   32'(tc),   32'(m_tc));
        chk("hex0", 32'(hex0), 32'(SEG[m_q[3:0]]));
        chk("hex1", 32'(hex1), 32'(SEG[m_q[7:4]]));
        $display("t=%0t rst=%0b ld=%0b lv=%02h en=%0b -> q=%02h done=%0b tc=%0b hex1=%07b hex0=%07b",
                 $time, r, l, v, e, q, done, tc, hex1, hex0);
    endtask

    initial begin
        int tc_count;

        // 1. Reset with Load held high: load is ignored.
        step(1, 1, 8'h77, 1);
        step(1, 1, 8'h77, 1);
        chk("t1_q", 32'(q), 32'h00);
        chk("t1_done", 32'(done), 32'h0);
        chk("t1_tc", 32'(tc), 32'h0);
        chk("t1_hex0", 32'(hex0), 32'b1000000);
        chk("t1_hex1", 32'(hex1), 32'b1000000);

        // 2. Load 3 and run to zero at TICK_DIV spacing.
        step(0, 1, 8'h03, 1);
        chk("t2_q_load", 32'(q), 32'h03);
        for (int k = 1; k <= 3; k++) begin
            repeat (TICK_DIV - 1) step(0, 0, 8'h00, 1);
            chk("t2_q_hold", 32'(q), 32'(4 - k));
            step(0, 0, 8'h00, 1);
            chk("t2_q_step", 32'(q), 32'(3 - k));
        end
        chk("t2_tc", 32'(tc), 32'h1);
        chk("t2_done", 32'(done), 32'h1);
        tc_count = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 8'h00, 1);
            if (tc) tc_count++;
        end
        chk("t2_q_stay", 32'(q), 32'h00);
        chk("t2_tc_quiet", 32'(tc_count), 32'd0);

        // 3. Pause mid-prescale and resume from the held prescaler.
        step(0, 1, 8'h10, 1);
        repeat (6) step(0, 0, 8'h00, 1);
        chk("t3_q_pre", 32'(q), 32'h0F);
        repeat (10) step(0, 0, 8'h00, 0);
        chk("t3_q_pause", 32'(q), 32'h0F);
        step(0, 0, 8'h00, 1);
        chk("t3_q_resume1", 32'(q), 32'h0F);
        step(0, 0, 8'h00, 1);
        chk("t3_q_resume2", 32'(q), 32'h0E);

        // 4. Reload mid-count from 3C.
        step(0, 1, 8'h3D, 1);
        repeat (TICK_DIV) step(0, 0, 8'h00, 1);
        chk("t4_q_3c", 32'(q), 32'h3C);
        repeat (2) step(0, 0, 8'h00, 1);
        step(0, 1, 8'hA5, 1);
        chk("t4_q_a5", 32'(q), 32'hA5);
        chk("t4_hex1", 32'(hex1), 32'b0001000);
        chk("t4_hex0", 32'(hex0), 32'b0010010);
        repeat (TICK_DIV - 1) step(0, 0, 8'h00, 1);
        chk("t4_q_restart", 32'(q), 32'hA5);
        step(0, 0, 8'h00, 1);
        chk("t4_q_a4", 32'(q), 32'hA4);

        // 5. Load zero goes straight to done without a pulse.
        step(0, 1, 8'h00, 1);
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_tc", 32'(tc), 32'h0);
        chk("t5_q", 32'(q), 32'h00);
        repeat (6) step(0, 0, 8'h00, 1);

        // 6. Reset while running at 42.
        step(0, 1, 8'h43, 1);
        repeat (TICK_DIV) step(0, 0, 8'h00, 1);
        chk("t6_q_42", 32'(q), 32'h42);
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        chk("t6_q", 32'(q), 32'h00);
        chk("t6_done", 32'(done), 32'h0);
        chk("t6_tc", 32'(tc), 32'h0);
        step(0, 0, 8'h00, 1);
        chk("t6_idle_q", 32'(q), 32'h00);

        // Random traffic, biased toward small load values so zero is reached often.
        for (int k = 0; k < 600; k++) begin
            logic       r_r, r_l, r_e;
            logic [7:0] r_v;
            r_r = ($urandom_range(0, 99) < 2);
            r_l = ($urandom_range(0, 99) < 6);
            r_v = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            r_e = ($urandom_range(0, 9) < 8);
            step(r_r, r_l, r_v, r_e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
